// File: rtl/gameover_banner_ctrl_pkg.sv
// Shared definitions for the game-over banner controller and related sprite logic.
// Provides the banner FSM state encoding, screen geometry, default banner size,
// the 11-bit pixel coordinate type and a small helper for sizing counters.
package gameover_pkg;

   typedef logic [10:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLIDE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_BLINK = 2'd3
   } gameover_state_e;

   localparam int unsigned SCREEN_WIDTH     = 32'd640;
   localparam int unsigned SCREEN_HEIGHT    = 32'd480;
   localparam int unsigned DEFAULT_BANNER_W = 32'd32;
   localparam int unsigned DEFAULT_BANNER_H = 32'd32;

   // Larger of two unsigned values, used to size frame counters at elaboration.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gameover_banner_ctrl_rect_hit_test.sv
// Combinational rectangle hit test shared by the sprite controllers.
// Reports whether a pixel lies inside [left, left+size_x) x [top, top+size_y)
// and the raw pixel offsets from the top-left corner. The right/bottom
// bounds are formed in 12 bits so a rectangle touching the coordinate limit
// cannot wrap around.
module rect_hit_test
   import gameover_pkg::*;
(
   input  logic [10:0] pixel_x_i,
   input  logic [10:0] pixel_y_i,
   input  logic [10:0] left_x_i,
   input  logic [10:0] top_y_i,
   input  logic [10:0] size_x_i,
   input  logic [10:0] size_y_i,
   output logic        hit_o,
   output logic [10:0] off_x_o,
   output logic [10:0] off_y_o
);

   logic [11:0] right_s;
   logic [11:0] bottom_s;

   // Unsigned bounds compare and offset subtraction.
   always_comb begin
      right_s  = {1'b0, left_x_i} + {1'b0, size_x_i};
      bottom_s = {1'b0, top_y_i}  + {1'b0, size_y_i};
      hit_o    = (pixel_x_i >= left_x_i) && ({1'b0, pixel_x_i} < right_s) &&
                 (pixel_y_i >= top_y_i)  && ({1'b0, pixel_y_i} < bottom_s);
      off_x_o  = pixel_x_i - left_x_i;
      off_y_o  = pixel_y_i - top_y_i;
   end

endmodule

// File: rtl/gameover_banner_ctrl.sv
// Game-over banner position/animation controller.
// Slides the banner down from START_Y to TARGET_Y one step per frame, holds it
// for HOLD_FRAMES frames, then (optionally) blinks it. Position and frame
// counter only change on startOfFrame so a frame is never drawn half-moved.
// Offsets and insideRectangle are registered one clock after the pixel.
// Build option: define GAMEOVER_BLINK_EN to add the BLINK state; without it
// HOLD is terminal and the banner stays visible until the FSM returns to IDLE.
module gameover_banner_ctrl
   import gameover_pkg::*;
#(
   parameter int unsigned OBJECT_WIDTH_X = DEFAULT_BANNER_W,
   parameter int unsigned OBJECT_HEIGHT_Y = DEFAULT_BANNER_H,
   parameter int unsigned TARGET_X       = 32'd304,
   parameter int unsigned TARGET_Y       = 32'd224,
   parameter int unsigned START_Y        = 32'd0,
   parameter int unsigned SLIDE_STEP     = 32'd4,
   parameter int unsigned HOLD_FRAMES    = 32'd60,
   parameter int unsigned BLINK_PERIOD   = 32'd16
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        gameOver,
   input  logic        restart,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        insideRectangle,
   output logic        bannerActive,
   output logic        bannerDone
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] SLIDE = ST_SLIDE;
   localparam logic [1:0] HOLD  = ST_HOLD;
`ifdef GAMEOVER_BLINK_EN
   localparam logic [1:0] BLINK = ST_BLINK;
`endif

   // Counter wide enough for both the hold count and a full blink cycle.
   localparam int unsigned CNT_W = $clog2(max_u(HOLD_FRAMES, 32'd2 * BLINK_PERIOD) + 32'd1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 32'd1);
`ifdef GAMEOVER_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(32'd2 * BLINK_PERIOD - 32'd1);
   localparam logic [CNT_W-1:0] BLINK_HALF = CNT_W'(BLINK_PERIOD);
`endif

   localparam logic [10:0] TGT_X   = 11'(TARGET_X);
   localparam logic [10:0] TGT_Y   = 11'(TARGET_Y);
   localparam logic [10:0] ST_Y    = 11'(START_Y);
   localparam logic [10:0] OBJ_W   = 11'(OBJECT_WIDTH_X);
   localparam logic [10:0] OBJ_H   = 11'(OBJECT_HEIGHT_Y);
   localparam logic [11:0] TGT_Y_W = 12'(TARGET_Y);
   localparam logic [11:0] STEP_W  = 12'(SLIDE_STEP);

   logic [1:0]       state_q, state_d;
   logic [10:0]      topY_q, topY_d;
   logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
   logic             done_q, done_d;
   logic [10:0]      offsetX_q, offsetY_q;
   logic             inside_q, active_q;

   logic [11:0]      slide_sum_s;
   logic             raw_hit_s, visible_s, hit_s;
   logic [10:0]      raw_off_x_s, raw_off_y_s;

   rect_hit_test u_hit (
      .pixel_x_i (pixelX),
      .pixel_y_i (pixelY),
      .left_x_i  (TGT_X),
      .top_y_i   (topY_q),
      .size_x_i  (OBJ_W),
      .size_y_i  (OBJ_H),
      .hit_o     (raw_hit_s),
      .off_x_o   (raw_off_x_s),
      .off_y_o   (raw_off_y_s)
   );

   // Next-state logic: abort has priority, otherwise advance once per frame.
   always_comb begin
      state_d     = state_q;
      topY_d      = topY_q;
      frameCnt_d  = frameCnt_q;
      done_d      = done_q;
      slide_sum_s = {1'b0, topY_q} + STEP_W;
      if (restart || !gameOver) begin
         state_d    = IDLE;
         topY_d     = ST_Y;
         frameCnt_d = '0;
         done_d     = 1'b0;
      end else if (startOfFrame) begin
         case (state_q)
            IDLE: begin
               state_d    = SLIDE;
               topY_d     = ST_Y;
               frameCnt_d = '0;
            end
            SLIDE: begin
               if (slide_sum_s >= TGT_Y_W) begin
                  topY_d     = TGT_Y;
                  frameCnt_d = '0;
                  state_d    = HOLD;
               end else begin
                  topY_d     = slide_sum_s[10:0];
               end
            end
            HOLD: begin
               if (frameCnt_q >= HOLD_LAST) begin
                  done_d = 1'b1;
`ifdef GAMEOVER_BLINK_EN
                  state_d    = BLINK;
                  frameCnt_d = '0;
`else
                  frameCnt_d = HOLD_LAST;
`endif
               end else begin
                  frameCnt_d = frameCnt_q + 1'b1;
               end
            end
`ifdef GAMEOVER_BLINK_EN
            BLINK: begin
               if (frameCnt_q >= BLINK_LAST) begin
                  frameCnt_d = '0;
               end else begin
                  frameCnt_d = frameCnt_q + 1'b1;
               end
            end
`endif
            default: begin
               state_d    = IDLE;
               topY_d     = ST_Y;
               frameCnt_d = '0;
               done_d     = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Banner hit: only while animating, and blanked in the hidden blink half.
   always_comb begin
      visible_s = 1'b1;
`ifdef GAMEOVER_BLINK_EN
      if ((state_q == BLINK) && (frameCnt_q >= BLINK_HALF)) begin
         visible_s = 1'b0;
      end else begin
         visible_s = 1'b1;
      end
`endif
      hit_s = raw_hit_s && (state_q != IDLE) && visible_s;
   end

   // FSM and animation registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         topY_q     <= ST_Y;
         frameCnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         topY_q     <= topY_d;
         frameCnt_q <= frameCnt_d;
         done_q     <= done_d;
      end
   end

   // Registered renderer outputs; offsets are zeroed whenever there is no hit.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         offsetX_q <= 11'd0;
         offsetY_q <= 11'd0;
         inside_q  <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         offsetX_q <= hit_s ? raw_off_x_s : 11'd0;
         offsetY_q <= hit_s ? raw_off_y_s : 11'd0;
         inside_q  <= hit_s;
         active_q  <= (state_q != IDLE);
      end
   end

   assign offsetX         = offsetX_q;
   assign offsetY         = offsetY_q;
   assign insideRectangle = inside_q;
   assign bannerActive    = active_q;
   assign bannerDone      = done_q;

endmodule

// File: tb/tb_gameover_banner_ctrl.sv
// Directed self-checking bench for gameover_banner_ctrl (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gameover_banner_ctrl;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [10:0] pixelX = 11'd0;
   logic [10:0] pixelY = 11'd0;
   logic        startOfFrame = 1'b0;
   logic        gameOver = 1'b0;
   logic        restart = 1'b0;
   logic [10:0] offsetX, offsetY;
   logic        insideRectangle, bannerActive, bannerDone;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gameover_banner_ctrl dut (
      .clk             (clk),
      .resetN          (resetN),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .startOfFrame    (startOfFrame),
      .gameOver        (gameOver),
      .restart         (restart),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .insideRectangle (insideRectangle),
      .bannerActive    (bannerActive),
      .bannerDone      (bannerDone)
   );

   task automatic pulse_sof();
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   task automatic drive_pixel(input logic [10:0] x, input logic [10:0] y);
      @(negedge clk);
      pixelX = x;
      pixelY = y;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({insideRectangle, bannerActive, bannerDone, offsetX, offsetY} !== 25'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {insideRectangle, bannerActive, bannerDone, offsetX, offsetY});
      end
      @(negedge clk);
      resetN = 1'b1;
      gameOver = 1'b1;
      pulse_sof();
      repeat (25) pulse_sof();
      drive_pixel(11'd310, 11'd110);
      checks++;
      if (insideRectangle !== 1'b1 || offsetX !== 11'd6 || offsetY !== 11'd10) begin
         errors++;
         $display("FAIL midslide_hit got in=%0b ox=%0d oy=%0d want in=1 ox=6 oy=10",
                  insideRectangle, offsetX, offsetY);
      end
      #2;
      resetN = 1'b0;
      #1;
      checks++;
      if ({insideRectangle, bannerActive, bannerDone, offsetX, offsetY} !== 25'd0) begin
         errors++;
         $display("FAIL async_reset got %h want 0",
                  {insideRectangle, bannerActive, bannerDone, offsetX, offsetY});
      end
      @(negedge clk);
      resetN = 1'b1;
      drive_pixel(11'd310, 11'd10);
      checks++;
      if (insideRectangle !== 1'b0 || bannerActive !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got in=%0b act=%0b want 0 0", insideRectangle, bannerActive);
      end
      pulse_sof();
      drive_pixel(11'd304, 11'd0);
      checks++;
      if (insideRectangle !== 1'b1 || offsetX !== 11'd0 || offsetY !== 11'd0) begin
         errors++;
         $display("FAIL post_reset_topY got in=%0b ox=%0d oy=%0d want 1 0 0",
                  insideRectangle, offsetX, offsetY);
      end
      @(negedge clk);
      gameOver = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_slide();
      int unsigned exp_top;
      gameOver = 1'b1;
      pulse_sof();
      drive_pixel(11'd304, 11'd0);
      checks++;
      if (insideRectangle !== 1'b1 || bannerActive !== 1'b1 || offsetX !== 11'd0 || offsetY !== 11'd0) begin
         errors++;
         $display("FAIL slide_start got in=%0b act=%0b ox=%0d oy=%0d want 1 1 0 0",
                  insideRectangle, bannerActive, offsetX, offsetY);
      end
      for (int k = 1; k <= 56; k++) begin
         pulse_sof();
         exp_top = 4 * k;
         drive_pixel(11'd306, 11'(exp_top));
         checks++;
         if (insideRectangle !== 1'b1 || offsetX !== 11'd2 || offsetY !== 11'd0 || bannerActive !== 1'b1) begin
            errors++;
            $display("FAIL slide_top k=%0d got in=%0b ox=%0d oy=%0d act=%0b want 1 2 0 1",
                     k, insideRectangle, offsetX, offsetY, bannerActive);
         end
         drive_pixel(11'd306, 11'(exp_top - 1));
         checks++;
         if (insideRectangle !== 1'b0 || offsetY !== 11'd0) begin
            errors++;
            $display("FAIL slide_above k=%0d got in=%0b oy=%0d want 0 0", k, insideRectangle, offsetY);
         end
      end
   endtask

   task automatic test_hold_hit();
      logic [10:0] xs [6] = '{11'd304, 11'd335, 11'd336, 11'd303, 11'd304, 11'd304};
      logic [10:0] ys [6] = '{11'd224, 11'd255, 11'd224, 11'd224, 11'd256, 11'd223};
      logic        ei [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [10:0] ex [6] = '{11'd0, 11'd31, 11'd0, 11'd0, 11'd0, 11'd0};
      logic [10:0] ey [6] = '{11'd0, 11'd31, 11'd0, 11'd0, 11'd0, 11'd0};
      for (int i = 0; i < 6; i++) begin
         drive_pixel(xs[i], ys[i]);
         checks++;
         if (insideRectangle !== ei[i] || offsetX !== ex[i] || offsetY !== ey[i]) begin
            errors++;
            $display("FAIL hold_hit (%0d,%0d) got in=%0b ox=%0d oy=%0d want in=%0b ox=%0d oy=%0d",
                     xs[i], ys[i], insideRectangle, offsetX, offsetY, ei[i], ex[i], ey[i]);
         end
      end
   endtask

   task automatic test_done_and_visibility();
      logic exp_in;
      for (int f = 1; f <= 60; f++) begin
         pulse_sof();
         checks++;
         if (bannerDone !== (f == 60)) begin
            errors++;
            $display("FAIL banner_done frame=%0d got %0b want %0b", f, bannerDone, (f == 60));
         end
      end
`ifdef GAMEOVER_BLINK_EN
      for (int j = 0; j < 64; j++) begin
         if (j > 0) pulse_sof();
         drive_pixel(11'd310, 11'd230);
         exp_in = ((j % 32) < 16);
         checks++;
         if (insideRectangle !== exp_in || offsetX !== (exp_in ? 11'd6 : 11'd0) || offsetY !== (exp_in ? 11'd6 : 11'd0)) begin
            errors++;
            $display("FAIL blink j=%0d got in=%0b ox=%0d oy=%0d want in=%0b", j, insideRectangle, offsetX, offsetY, exp_in);
         end
      end
      pulse_sof();
`else
      exp_in = 1'b1;
      for (int j = 0; j < 40; j++) begin
         if (j > 0) pulse_sof();
         drive_pixel(11'd310, 11'd230);
         checks++;
         if (insideRectangle !== exp_in || bannerDone !== 1'b1 || offsetX !== 11'd6 || offsetY !== 11'd6) begin
            errors++;
            $display("FAIL steady j=%0d got in=%0b done=%0b ox=%0d oy=%0d want 1 1 6 6",
                     j, insideRectangle, bannerDone, offsetX, offsetY);
         end
      end
`endif
   endtask

   task automatic test_restart();
      drive_pixel(11'd310, 11'd230);
      checks++;
      if (insideRectangle !== 1'b1 || bannerDone !== 1'b1) begin
         errors++;
         $display("FAIL pre_restart got in=%0b done=%0b want 1 1", insideRectangle, bannerDone);
      end
      @(negedge clk);
      restart = 1'b1;
      startOfFrame = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      startOfFrame = 1'b0;
      checks++;
      if (bannerDone !== 1'b0) begin
         errors++;
         $display("FAIL restart_done got %0b want 0", bannerDone);
      end
      drive_pixel(11'd310, 11'd230);
      checks++;
      if (insideRectangle !== 1'b0 || bannerActive !== 1'b0 || offsetX !== 11'd0) begin
         errors++;
         $display("FAIL restart_idle got in=%0b act=%0b ox=%0d want 0 0 0", insideRectangle, bannerActive, offsetX);
      end
      drive_pixel(11'd304, 11'd0);
      checks++;
      if (insideRectangle !== 1'b0 || offsetY !== 11'd0) begin
         errors++;
         $display("FAIL restart_top got in=%0b oy=%0d want 0 0", insideRectangle, offsetY);
      end
   endtask

   task automatic test_gameover_drop();
      pulse_sof();
      repeat (10) pulse_sof();
      drive_pixel(11'd304, 11'd40);
      checks++;
      if (insideRectangle !== 1'b1 || offsetY !== 11'd0) begin
         errors++;
         $display("FAIL drop_pre got in=%0b oy=%0d want 1 0", insideRectangle, offsetY);
      end
      @(negedge clk);
      gameOver = 1'b0;
      @(negedge clk);
      gameOver = 1'b1;
      drive_pixel(11'd304, 11'd40);
      checks++;
      if (insideRectangle !== 1'b0 || bannerActive !== 1'b0) begin
         errors++;
         $display("FAIL drop_idle got in=%0b act=%0b want 0 0", insideRectangle, bannerActive);
      end
      pulse_sof();
      drive_pixel(11'd304, 11'd0);
      checks++;
      if (insideRectangle !== 1'b1 || offsetY !== 11'd0 || bannerActive !== 1'b1) begin
         errors++;
         $display("FAIL drop_reslide got in=%0b oy=%0d act=%0b want 1 0 1", insideRectangle, offsetY, bannerActive);
      end
      drive_pixel(11'd304, 11'd40);
      checks++;
      if (insideRectangle !== 1'b0) begin
         errors++;
         $display("FAIL drop_reslide_below got in=%0b want 0", insideRectangle);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_slide();
      test_hold_hit();
      test_done_and_visibility();
      test_restart();
      test_gameover_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
